// File: rtl/sb_pkg.sv
// Shared types for the post-commit store buffer: entry layout, drain FSM states, default depth.
// No logic; imported by store_buffer and sb_fwd_match.
// Backpressure is not applicable to a package.
package sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        valid;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_WRITE = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search of a load word address over the buffered stores.
// Latency: combinational, same cycle.
// Backpressure: none; pure lookup.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_SIZE = $clog2(SB_DEPTH)
) (
    input  sb_entry_t         entries [SB_DEPTH],
    input  logic [PTR_SIZE:0] rd_ptr,
    input  logic [PTR_SIZE:0] wr_ptr,
    input  logic              ld_val,
    input  logic [31:0]       ld_addr,
    output logic              fwd_hit,
    output logic [31:0]       fwd_data
);

    localparam logic [PTR_SIZE:0] PTR_ONE = (PTR_SIZE+1)'(1);

    logic [PTR_SIZE:0] occ;
    logic [PTR_SIZE:0] idx;

    assign occ = wr_ptr - rd_ptr;

    // Walk from the youngest entry (wr_ptr-1) toward the head; first match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = wr_ptr - PTR_ONE - (PTR_SIZE+1)'(i);
            if (ld_val && !fwd_hit && ((PTR_SIZE+1)'(i) < occ)
                && entries[idx[PTR_SIZE-1:0]].valid
                && (entries[idx[PTR_SIZE-1:0]].addr == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx[PTR_SIZE-1:0]].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order post-commit store buffer draining to the data cache; optional load forwarding under SB_LOAD_FWD_EN.
// Latency: push in cycle N -> cache request at N+2; ack in M -> next head presented at M+1.
// Backpressure: sb_full stalls ROB store commit; cache paces the drain with dc_sb_ack.
module store_buffer
    import sb_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        rob_commitmemwrite,
    input  logic [31:0] rob_swaddr,
    input  logic [31:0] rob_swdata,
    output logic        sb_full,
    output logic        sb_empty,
    output logic        sb_dc_wr_en,
    output logic [31:0] sb_dc_addr,
    output logic [31:0] sb_dc_data,
    input  logic        dc_sb_ack,
    input  logic        lsq_ld_val,
    input  logic [31:0] lsq_ld_addr,
    output logic        sb_fwd_hit,
    output logic [31:0] sb_fwd_data
);

    localparam int PTR_SIZE = $clog2(SB_DEPTH);
    localparam logic [PTR_SIZE:0] PTR_ONE = (PTR_SIZE+1)'(1);

    sb_entry_t         entries [SB_DEPTH];
    logic [PTR_SIZE:0] wr_ptr, rd_ptr;
    logic [PTR_SIZE:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [PTR_SIZE:0] occ_nxt;
    logic              push, pop;
    sb_state_e         state, state_nxt;
    sb_entry_t         head;

    assign sb_full  = (wr_ptr[PTR_SIZE-1:0] == rd_ptr[PTR_SIZE-1:0])
                   && (wr_ptr[PTR_SIZE] != rd_ptr[PTR_SIZE]);
    assign sb_empty = (wr_ptr == rd_ptr);

    assign push       = rob_commitmemwrite && !sb_full;
    assign pop        = (state == SB_WRITE) && dc_sb_ack;
    assign wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    assign head       = entries[rd_ptr[PTR_SIZE-1:0]];

    // Push and pop never target the same slot: that needs full (no push) or empty (no pop).
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (push) begin
                entries[wr_ptr[PTR_SIZE-1:0]] <= '{addr: rob_swaddr, data: rob_swdata, valid: 1'b1};
            end
            if (pop) begin
                entries[rd_ptr[PTR_SIZE-1:0]].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            assert (!(rob_commitmemwrite && sb_full))
                else $error("store_buffer: commit while full, store dropped");
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= SB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SB_IDLE:  if (!sb_empty) state_nxt = SB_WRITE;
            SB_WRITE: if (dc_sb_ack && (occ_nxt == '0)) state_nxt = SB_IDLE;
            default:  state_nxt = SB_IDLE;
        endcase
    end

    // Head fields are only driven during a request so idle/reset outputs read as zero.
    always_comb begin
        sb_dc_wr_en = 1'b0;
        sb_dc_addr  = '0;
        sb_dc_data  = '0;
        if (state == SB_WRITE) begin
            sb_dc_wr_en = 1'b1;
            sb_dc_addr  = head.addr;
            sb_dc_data  = head.data;
        end
    end

`ifdef SB_LOAD_FWD_EN
    sb_fwd_match #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fwd (
        .entries  (entries),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .ld_val   (lsq_ld_val),
        .ld_addr  (lsq_ld_addr),
        .fwd_hit  (sb_fwd_hit),
        .fwd_data (sb_fwd_data)
    );
`else
    logic unused_ld;
    assign unused_ld   = ^{lsq_ld_val, lsq_ld_addr};
    assign sb_fwd_hit  = 1'b0;
    assign sb_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, single store, fill, wrap, forwarding, reset mid-drain.
module tb_store_buffer;

`ifdef SB_LOAD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_b;
    logic        rob_commitmemwrite;
    logic [31:0] rob_swaddr;
    logic [31:0] rob_swdata;
    logic        sb_full;
    logic        sb_empty;
    logic        sb_dc_wr_en;
    logic [31:0] sb_dc_addr;
    logic [31:0] sb_dc_data;
    logic        dc_sb_ack;
    logic        lsq_ld_val;
    logic [31:0] lsq_ld_addr;
    logic        sb_fwd_hit;
    logic [31:0] sb_fwd_data;

    int checks = 0;
    int errors = 0;

    store_buffer #(.SB_DEPTH(4)) dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .rob_commitmemwrite (rob_commitmemwrite),
        .rob_swaddr         (rob_swaddr),
        .rob_swdata         (rob_swdata),
        .sb_full            (sb_full),
        .sb_empty           (sb_empty),
        .sb_dc_wr_en        (sb_dc_wr_en),
        .sb_dc_addr         (sb_dc_addr),
        .sb_dc_data         (sb_dc_data),
        .dc_sb_ack          (dc_sb_ack),
        .lsq_ld_val         (lsq_ld_val),
        .lsq_ld_addr        (lsq_ld_addr),
        .sb_fwd_hit         (sb_fwd_hit),
        .sb_fwd_data        (sb_fwd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        rob_commitmemwrite = 1'b1;
        rob_swaddr         = a;
        rob_swdata         = d;
        tick();
        rob_commitmemwrite = 1'b0;
    endtask

    task automatic ack();
        dc_sb_ack = 1'b1;
        tick();
        dc_sb_ack = 1'b0;
    endtask

    initial begin
        rst_b              = 1'b0;
        rob_commitmemwrite = 1'b0;
        rob_swaddr         = '0;
        rob_swdata         = '0;
        dc_sb_ack          = 1'b0;
        lsq_ld_val         = 1'b0;
        lsq_ld_addr        = '0;

        // Reset
        tick();
        tick();
        check("rst_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_full",  {31'd0, sb_full}, 32'd0);
        check("rst_wr_en", {31'd0, sb_dc_wr_en}, 32'd0);
        check("rst_addr",  sb_dc_addr, 32'h0);
        check("rst_data",  sb_dc_data, 32'h0);
        check("rst_hit",   {31'd0, sb_fwd_hit}, 32'd0);
        rst_b = 1'b1;
        tick();
        tick();

        // Single store: request appears two cycles after the push
        push(32'h100, 32'hDEAD);
        check("single_n1_wr_en", {31'd0, sb_dc_wr_en}, 32'd0);
        check("single_n1_empty", {31'd0, sb_empty}, 32'd0);
        tick();
        check("single_n2_wr_en", {31'd0, sb_dc_wr_en}, 32'd1);
        check("single_addr", sb_dc_addr, 32'h100);
        check("single_data", sb_dc_data, 32'hDEAD);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_wr_en", {31'd0, sb_dc_wr_en}, 32'd1);
            check("hold_addr", sb_dc_addr, 32'h100);
            check("hold_data", sb_dc_data, 32'hDEAD);
        end
        ack();
        check("single_done_empty", {31'd0, sb_empty}, 32'd1);
        check("single_done_wr_en", {31'd0, sb_dc_wr_en}, 32'd0);

        // Fill to full without acks
        for (int i = 0; i < 4; i++) begin
            push(32'h200 + 32'(i), 32'h1000 + 32'(i));
        end
        check("fill_full", {31'd0, sb_full}, 32'd1);
        check("fill_head", sb_dc_addr, 32'h200);
        ack();
        check("pop_clears_full", {31'd0, sb_full}, 32'd0);
        check("no_bubble_wr_en", {31'd0, sb_dc_wr_en}, 32'd1);
        check("no_bubble_addr", sb_dc_addr, 32'h201);
        // Simultaneous push and pop keeps occupancy at 3
        rob_commitmemwrite = 1'b1;
        rob_swaddr         = 32'h204;
        rob_swdata         = 32'h1004;
        dc_sb_ack          = 1'b1;
        tick();
        rob_commitmemwrite = 1'b0;
        dc_sb_ack          = 1'b0;
        check("pushpop_full", {31'd0, sb_full}, 32'd0);
        check("pushpop_head", sb_dc_addr, 32'h202);
        push(32'h205, 32'h1005);
        check("refill_full", {31'd0, sb_full}, 32'd1);
        for (int i = 2; i < 6; i++) begin
            check("fill_drain_addr", sb_dc_addr, 32'h200 + 32'(i));
            check("fill_drain_data", sb_dc_data, 32'h1000 + 32'(i));
            ack();
        end
        check("fill_drain_empty", {31'd0, sb_empty}, 32'd1);

        // Pointer wrap over many push/ack pairs
        for (int j = 0; j < 10; j++) begin
            push(32'h300 + 32'(j), 32'h3000 + 32'(j));
            tick();
            check("wrap_addr", sb_dc_addr, 32'h300 + 32'(j));
            check("wrap_data", sb_dc_data, 32'h3000 + 32'(j));
            ack();
        end
        check("wrap_empty", {31'd0, sb_empty}, 32'd1);

        // Forwarding: youngest of two stores to the same address
        lsq_ld_val  = 1'b1;
        lsq_ld_addr = 32'h40;
        #1;
        check("fwd_before_hit", {31'd0, sb_fwd_hit}, 32'd0);
        push(32'h40, 32'h1);
        check("fwd_first_hit",  {31'd0, sb_fwd_hit}, {31'd0, FWD});
        check("fwd_first_data", sb_fwd_data, FWD ? 32'h1 : 32'h0);
        push(32'h40, 32'h2);
        check("fwd_young_hit",  {31'd0, sb_fwd_hit}, {31'd0, FWD});
        check("fwd_young_data", sb_fwd_data, FWD ? 32'h2 : 32'h0);
        lsq_ld_addr = 32'h44;
        #1;
        check("fwd_miss_hit", {31'd0, sb_fwd_hit}, 32'd0);
        lsq_ld_val  = 1'b0;
        lsq_ld_addr = 32'h40;
        #1;
        check("fwd_noval_hit", {31'd0, sb_fwd_hit}, 32'd0);
        lsq_ld_val = 1'b1;
        check("fwd_drain_head", sb_dc_addr, 32'h40);
        ack();
        check("fwd_after_pop1_hit",  {31'd0, sb_fwd_hit}, {31'd0, FWD});
        check("fwd_after_pop1_data", sb_fwd_data, FWD ? 32'h2 : 32'h0);
        ack();
        check("fwd_after_pop2_hit", {31'd0, sb_fwd_hit}, 32'd0);
        check("fwd_after_pop2_empty", {31'd0, sb_empty}, 32'd1);
        lsq_ld_val = 1'b0;

        // Reset while draining
        for (int i = 0; i < 3; i++) begin
            push(32'h500 + 32'(i), 32'h5000 + 32'(i));
        end
        check("middrain_wr_en", {31'd0, sb_dc_wr_en}, 32'd1);
        rst_b = 1'b0;
        tick();
        check("middrain_empty", {31'd0, sb_empty}, 32'd1);
        check("middrain_full",  {31'd0, sb_full}, 32'd0);
        check("middrain_wr_en_low", {31'd0, sb_dc_wr_en}, 32'd0);
        check("middrain_addr", sb_dc_addr, 32'h0);
        rst_b = 1'b1;
        push(32'h600, 32'h6000);
        tick();
        check("post_rst_addr", sb_dc_addr, 32'h600);
        check("post_rst_data", sb_dc_data, 32'h6000);
        ack();
        check("post_rst_empty", {31'd0, sb_empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
